// File: rtl/req_ack_mux_cdc.sv
// Round-robin mux of CH_NUM asynchronous 4-phase req/ack channels onto a single downstream req/ack pair.
// Optional downstream timeout is enabled by defining REQ_ACK_MUX_TIMEOUT_EN.
module req_ack_mux_cdc #(
    parameter int CH_NUM        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_WIDTH = 8,
    localparam int CW           = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk1,
    input  logic              rst_1,
    input  logic [CH_NUM-1:0] req_i,
    output logic [CH_NUM-1:0] ack_o,
    output logic              req_o,
    output logic [CW-1:0]     ch_id_o,
    input  logic              ack_i,
    output logic              pre_req_o,
    output logic              timeout_o
);

    if (CH_NUM < 2 || CH_NUM > 16) begin : g_bad_ch_num
        $error("CH_NUM must be in 2..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_WIDTH < 1) begin : g_bad_tw
        $error("TIMEOUT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q;
    logic [CH_NUM-1:0]                  req_s;
    logic [CH_NUM-1:0]                  pending;
    logic [CH_NUM-1:0]                  ack_q;
    logic                               req_q;
    logic                               pre_req_q;
    logic [CW-1:0]                      ch_id_q;
    logic [CW-1:0]                      last_grant_q;
    logic [CW-1:0]                      win_id;
    int                                 idx;
    state_t                             state_q;

    // Only this chain touches req_i; everything else works on req_s.
    always_ff @(posedge clk1 or posedge rst_1) begin
        if (rst_1) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign pending = req_s & ~ack_q;

    // Scan from farthest to nearest so the nearest pending index after last_grant wins.
    always_comb begin
        win_id = '0;
        idx    = 0;
        for (int k = CH_NUM; k >= 1; k--) begin
            idx = int'(last_grant_q) + k;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            if (pending[idx]) begin
                win_id = CW'(idx);
            end
        end
    end

`ifdef REQ_ACK_MUX_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_d;
    logic                     timeout_q;

    assign cnt_d     = cnt_q + 1'b1;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk1 or posedge rst_1) begin
        if (rst_1) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            req_q        <= 1'b0;
            pre_req_q    <= 1'b0;
            ch_id_q      <= '0;
            last_grant_q <= CW'(CH_NUM - 1);
`ifdef REQ_ACK_MUX_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            pre_req_q <= 1'b0;
`ifdef REQ_ACK_MUX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // Acks follow the synchronised request down regardless of FSM state.
            for (int i = 0; i < CH_NUM; i++) begin
                if (!req_s[i]) begin
                    ack_q[i] <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        state_q      <= ARB;
                        ch_id_q      <= win_id;
                        last_grant_q <= win_id;
                        pre_req_q    <= 1'b1;
                    end
                end
                ARB: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
`ifdef REQ_ACK_MUX_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                REQ: begin
                    if (ack_i) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        if (req_s[ch_id_q]) begin
                            ack_q[ch_id_q] <= 1'b1;
                        end
                    end
`ifdef REQ_ACK_MUX_TIMEOUT_EN
                    else if (&cnt_d) begin
                        state_q   <= DONE;
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= cnt_d;
                        if (req_s[ch_id_q]) begin
                            ack_q[ch_id_q] <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
`endif
                end
                DONE: begin
                    if (!ack_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign req_o     = req_q;
    assign pre_req_o = pre_req_q;
    assign ch_id_o   = ch_id_q;

endmodule

// File: tb/tb_req_ack_mux_cdc.sv
// Randomised bench for req_ack_mux_cdc against a transaction-level round-robin model.
module tb_req_ack_mux_cdc;

    localparam int CH = 4;

    logic          clk1;
    logic          rst_1;
    logic [CH-1:0] req_i;
    logic [CH-1:0] ack_o;
    logic          req_o;
    logic [1:0]    ch_id_o;
    logic          ack_i;
    logic          pre_req_o;
    logic          timeout_o;

    int n_chk;
    int n_fail;
    int last_gnt;

    req_ack_mux_cdc #(
        .CH_NUM        (CH),
        .SYNC_STAGES   (2),
        .TIMEOUT_WIDTH (4)
    ) dut (
        .clk1      (clk1),
        .rst_1     (rst_1),
        .req_i     (req_i),
        .ack_o     (ack_o),
        .req_o     (req_o),
        .ch_id_o   (ch_id_o),
        .ack_i     (ack_i),
        .pre_req_o (pre_req_o),
        .timeout_o (timeout_o)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Reference: first pending channel strictly after the last grant, wrapping.
    function automatic int rr_pick(input logic [CH-1:0] pend, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (pend[(last + k) % CH]) return (last + k) % CH;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst_1 = 1'b1;
        tick();
        tick();
        rst_1 = 1'b0;
        last_gnt = CH - 1;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (req_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("req_rise", {31'b0, req_o}, 32'd1);
    endtask

    task automatic serve(input int exp_ch, input int ack_dly);
        wait_req(20);
        chk("grant_ch", {30'b0, ch_id_o}, exp_ch);
        repeat (ack_dly) tick();
        ack_i = 1'b1;
        tick();
        chk("done_req", {31'b0, req_o}, 32'd0);
        chk("done_ack", {31'b0, ack_o[exp_ch]}, 32'd1);
        ack_i = 1'b0;
        tick();
        last_gnt = exp_ch;
    endtask

    initial begin
        logic [CH-1:0] pat;
        logic [CH-1:0] acked;
        int            exp_ch;
        int            n;

        n_chk    = 0;
        n_fail   = 0;
        rst_1    = 1'b1;
        req_i    = '0;
        ack_i    = 1'b0;
        last_gnt = CH - 1;
        #1;
        chk("rst_ack", {28'b0, ack_o}, 32'd0);
        chk("rst_req", {31'b0, req_o}, 32'd0);
        chk("rst_pre", {31'b0, pre_req_o}, 32'd0);
        chk("rst_to", {31'b0, timeout_o}, 32'd0);
        chk("rst_ch", {30'b0, ch_id_o}, 32'd0);
        do_reset();

        // Single request on channel 2 with exact latency.
        req_i = 4'b0100;
        tick();
        chk("s_pre_e1", {31'b0, pre_req_o}, 32'd0);
        tick();
        chk("s_pre_e2", {31'b0, pre_req_o}, 32'd0);
        tick();
        chk("s_pre_e3", {31'b0, pre_req_o}, 32'd1);
        chk("s_req_e3", {31'b0, req_o}, 32'd0);
        tick();
        chk("s_req_e4", {31'b0, req_o}, 32'd1);
        chk("s_pre_e4", {31'b0, pre_req_o}, 32'd0);
        chk("s_ch_e4", {30'b0, ch_id_o}, 32'd2);
        tick();
        chk("s_req_e5", {31'b0, req_o}, 32'd1);
        ack_i = 1'b1;
        tick();
        chk("s_req_done", {31'b0, req_o}, 32'd0);
        chk("s_ack_set", {28'b0, ack_o}, 32'h4);
        ack_i = 1'b0;
        req_i = '0;
        tick();
        tick();
        chk("s_ack_hold", {31'b0, ack_o[2]}, 32'd1);
        tick();
        chk("s_ack_clr", {28'b0, ack_o}, 32'd0);

        // All four at once from reset, then no re-grant while held.
        do_reset();
        req_i = 4'b1111;
        acked = '0;
        for (int t = 0; t < CH; t++) begin
            exp_ch = rr_pick(req_i & ~acked, last_gnt);
            serve(exp_ch, 0);
            acked[exp_ch] = 1'b1;
        end
        n = 0;
        repeat (20) begin
            tick();
            if (req_o === 1'b1) n++;
        end
        chk("c_no_regrant", n, 32'd0);
        chk("c_ack_all", {28'b0, ack_o}, 32'hf);
        req_i = '0;
        repeat (4) tick();
        chk("c_ack_clr", {28'b0, ack_o}, 32'd0);

        // Random batches of held requests.
        for (int b = 0; b < 12; b++) begin
            pat   = 4'($urandom_range(1, 15));
            req_i = pat;
            acked = '0;
            for (int t = 0; t < $countones(pat); t++) begin
                exp_ch = rr_pick(pat & ~acked, last_gnt);
                serve(exp_ch, $urandom_range(0, 3));
                acked[exp_ch] = 1'b1;
            end
            n = 0;
            repeat (8) begin
                tick();
                if (req_o === 1'b1) n++;
            end
            chk("r_no_regrant", n, 32'd0);
            chk("r_ack", {28'b0, ack_o}, {28'b0, pat});
            req_i = '0;
            repeat (4) tick();
            chk("r_ack_clr", {28'b0, ack_o}, 32'd0);
        end

        // Abort: request withdrawn while req_o is high gets no ack.
        req_i = 4'b0010;
        wait_req(20);
        chk("a_ch", {30'b0, ch_id_o}, 32'd1);
        req_i = '0;
        repeat (3) tick();
        ack_i = 1'b1;
        tick();
        chk("a_req", {31'b0, req_o}, 32'd0);
        chk("a_ack", {28'b0, ack_o}, 32'd0);
        ack_i = 1'b0;
        repeat (2) tick();
        chk("a_ack_later", {28'b0, ack_o}, 32'd0);
        last_gnt = 1;

        // Downstream never acknowledges.
        req_i = 4'b0001;
        wait_req(20);
        n = 0;
`ifdef REQ_ACK_MUX_TIMEOUT_EN
        while (req_o === 1'b1 && timeout_o === 1'b0 && n < 200) begin
            n++;
            tick();
        end
        chk("t_req_cycles", n, 32'd15);
        chk("t_pulse", {31'b0, timeout_o}, 32'd1);
        chk("t_req", {31'b0, req_o}, 32'd0);
        chk("t_ack", {31'b0, ack_o[0]}, 32'd1);
        tick();
        chk("t_pulse_end", {31'b0, timeout_o}, 32'd0);
`else
        while (req_o === 1'b1 && timeout_o === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        chk("t_req_cycles", n, 32'd100);
        chk("t_no_pulse", {31'b0, timeout_o}, 32'd0);
        chk("t_req_held", {31'b0, req_o}, 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        chk("t_ack", {31'b0, ack_o[0]}, 32'd1);
`endif
        last_gnt = 0;
        req_i = '0;
        repeat (4) tick();
        chk("t_ack_clr", {28'b0, ack_o}, 32'd0);

        // Reset in the middle of a transaction, then normal restart.
        req_i  = 4'b1000;
        exp_ch = rr_pick(req_i, last_gnt);
        wait_req(20);
        chk("m_ch", {30'b0, ch_id_o}, exp_ch);
        tick();
        rst_1 = 1'b1;
        #1;
        chk("m_rst_req", {31'b0, req_o}, 32'd0);
        chk("m_rst_ack", {28'b0, ack_o}, 32'd0);
        chk("m_rst_pre", {31'b0, pre_req_o}, 32'd0);
        chk("m_rst_to", {31'b0, timeout_o}, 32'd0);
        chk("m_rst_ch", {30'b0, ch_id_o}, 32'd0);
        tick();
        tick();
        rst_1 = 1'b0;
        last_gnt = CH - 1;
        exp_ch = rr_pick(req_i, last_gnt);
        tick();
        chk("m_pre_e1", {31'b0, pre_req_o}, 32'd0);
        tick();
        chk("m_req_e2", {31'b0, req_o}, 32'd0);
        tick();
        chk("m_pre_e3", {31'b0, pre_req_o}, 32'd1);
        tick();
        chk("m_req_e4", {31'b0, req_o}, 32'd1);
        chk("m_ch_e4", {30'b0, ch_id_o}, exp_ch);
        chk("m_ack_e4", {28'b0, ack_o}, 32'd0);
        ack_i = 1'b1;
        tick();
        chk("m_ack_done", {28'b0, ack_o}, 32'h8);
        ack_i = 1'b0;
        req_i = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_mux_cdc.md
REQ_ACK_MUX_CDC -- requirements
Module: req_ack_mux_cdc

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of requester channels (range 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per req_i bit (minimum 2).
REQ-003 SHALL have parameter TIMEOUT_WIDTH, default 8, timeout counter width.
REQ-004 SHALL have port clk1  input  1  the single clock; all logic is in this domain.
REQ-005 SHALL have port rst_1  input  1  asynchronous reset, active high.
REQ-006 SHALL have port req_i  input  CH_NUM  per-channel 4-phase request levels, asynchronous to clk1.
REQ-007 SHALL have port ack_o  output  CH_NUM  per-channel 4-phase acknowledge levels, registered.
REQ-008 SHALL have port req_o  output  1  downstream request level, registered.
REQ-009 SHALL have port ch_id_o  output  max(1,$clog2(CH_NUM))  index of the granted channel, stable while req_o=1.
REQ-010 SHALL have port ack_i  input  1  downstream acknowledge level, synchronous to clk1.
REQ-011 SHALL have port pre_req_o  output  1  one-cycle pulse in the cycle before req_o rises.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse on downstream timeout.

Function
REQ-013 SHALL synchronise each req_i bit through SYNC_STAGES flops into req_s; no other logic SHALL sample req_i.
REQ-014 SHALL treat channel i as pending when req_s[i]=1 and ack_o[i]=0.
REQ-015 SHALL implement FSM states IDLE, ARB, REQ, DONE.
REQ-016 IDLE -> ARB when any channel is pending; otherwise it SHALL stay in IDLE.
REQ-017 ARB SHALL last exactly one cycle: it registers the winner into ch_id_o, drives pre_req_o=1, and goes to REQ.
REQ-018 Arbitration SHALL be round-robin: the first pending index strictly after last_grant (modulo CH_NUM) wins, and last_grant updates to the winner.
REQ-019 In REQ, req_o SHALL be 1; on ack_i=1, req_o SHALL clear at the next edge and the FSM SHALL go to DONE.
REQ-020 On the same edge, ack_o[ch_id_o] SHALL be set only if req_s[ch_id_o] is still 1 (an aborted request gets no ack).
REQ-021 DONE -> IDLE SHALL occur only when ack_i=0.
REQ-022 ack_i SHALL be ignored in IDLE and ARB.
REQ-023 ack_o[i] SHALL clear on the edge after req_s[i]=0, independent of FSM state.
REQ-024 A channel with ack_o[i]=1 SHALL NOT be re-granted until ack_o[i] has cleared and req_s[i] rises again.
REQ-025 Latency from idle: with edge 1 the first edge sampling req_i=1, pre_req_o=1 after edge SYNC_STAGES+1 and req_o=1 after edge SYNC_STAGES+2.
REQ-026 Simultaneous pending channels SHALL be served one per transaction in round-robin order, with no channel starved.

Reset
REQ-027 rst_1=1 SHALL asynchronously clear all synchroniser flops, ack_o, req_o, pre_req_o, timeout_o and ch_id_o to 0, set the FSM to IDLE, and set last_grant=CH_NUM-1, so channel 0 wins first.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no ack_o pulse after release; operation SHALL resume from IDLE on the first edge after release.

Configuration
REQ-029 Macro REQ_ACK_MUX_TIMEOUT_EN defined: a TIMEOUT_WIDTH counter SHALL clear on entry to REQ and increment each REQ cycle without ack_i.
REQ-030 On reaching all-ones without ack_i, the block SHALL clear req_o, pulse timeout_o for one cycle, set ack_o[ch_id_o] (subject to REQ-020), and go to DONE.
REQ-031 Macro REQ_ACK_MUX_TIMEOUT_EN undefined: no counter SHALL exist, timeout_o SHALL be tied to 0, and REQ SHALL wait indefinitely for ack_i.

Verification (CH_NUM=4, SYNC_STAGES=2, TIMEOUT_WIDTH=4)
REQ-032 Single request: raise req_i[2], ack_i one cycle after req_o -> pre_req_o after edge 3, req_o after edge 4, ch_id_o=2, ack_o[2]=1; drop req_i[2] -> ack_o[2]=0 within 3 cycles.
REQ-033 Contention: raise req_i=4'b1111 at once, auto-acking -> grants in order 0,1,2,3; with requests held high after ack, no channel is re-granted.
REQ-034 Abort: raise req_i[1], drop it while req_o=1, then assert ack_i -> req_o clears and ack_o[1] stays 0.
REQ-035 Timeout (macro defined): req_i[0] with ack_i held 0 -> timeout_o pulses after 15 REQ cycles, req_o=0, ack_o[0]=1; undefined -> req_o stays 1 for 100 cycles and timeout_o stays 0.
REQ-036 Reset mid-REQ: assert rst_1 while req_o=1 -> all outputs are 0 immediately; after release with req_i[3] held, the grant goes to channel 3 with normal latency.
